// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that borrows the external ALU for one partial-product add per clock.
// Optional macro MUL_EARLY_EXIT_EN: stop iterating once the remaining multiplier bits are all zero.
module alu_mul_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter logic [2:0]  OP_ADD = 3'b010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic                 alu_cin,
    output logic                 alu_less,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_mreg;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_shifted;
    logic [CW-1:0]        w_count_nx;
    logic                 w_last;
    logic                 w_early;
    logic [2*WIDTH-1:0]   w_early_product;

    assign w_accept   = start && (r_state != S_RUN);
    // Carry-out of the add is kept as the bit shifted into the top of hi.
    assign w_sum      = r_lo[0] ? {alu_cout, alu_result} : {1'b0, r_hi};
    assign w_shifted  = {w_sum, r_lo[WIDTH-1:1]};
    assign w_count_nx = r_count + CW'(1);
    assign w_last     = (w_count_nx == CW'(WIDTH));

`ifdef MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]     w_live_mask;

    // Unconsumed multiplier bits sit in lo[WIDTH-1-count:0]; once they are zero only shifts remain.
    assign w_live_mask     = {WIDTH{1'b1}} >> r_count;
    assign w_early         = ((r_lo & w_live_mask) == '0);
    assign w_early_product = {r_hi, r_lo} >> (CW'(WIDTH) - r_count);
`else
    assign w_early         = 1'b0;
    assign w_early_product = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_early || w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_mreg    <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mreg  <= mcand;
            r_hi    <= '0;
            r_lo    <= mplier;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            if (w_early) begin
                r_product <= w_early_product;
            end else begin
                {r_hi, r_lo} <= w_shifted;
                r_count      <= w_count_nx;
                if (w_last) begin
                    r_product <= w_shifted;
                end
            end
        end
    end

    assign product  = r_product;
    assign alu_a    = r_hi;
    assign alu_b    = r_mreg;
    assign alu_cin  = 1'b0;
    assign alu_less = 1'b0;
    assign alu_op   = OP_ADD;

endmodule
